// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-file dump engine.
// REG_DUMP_HDR_EN adds one index header byte in front of every register.
package reg_dump_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_SEND  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam int BYTES_PER_WORD = 4;
`ifdef REG_DUMP_HDR_EN
    localparam int HDR_BYTES = 1;
`else
    localparam int HDR_BYTES = 0;
`endif
    localparam int BYTES_PER_REG = BYTES_PER_WORD + HDR_BYTES;

    // Little-endian byte select from a 32-bit word.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [2:0] sel);
        logic [7:0] b;
        case (sel)
            3'd0:    b = word[7:0];
            3'd1:    b = word[15:8];
            3'd2:    b = word[23:16];
            3'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

`ifdef REG_DUMP_HDR_EN
    function automatic logic [7:0] hdr_byte(input logic [4:0] idx);
        return {3'b000, idx};
    endfunction
`endif

endpackage

// File: rtl/reg_dump_ser.sv
// Word-to-byte valid/ready serializer: snapshots one register and offers its bytes.
// With REG_DUMP_HDR_EN the register index is sent first as a header byte.
module reg_dump_ser
    import reg_dump_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] word,
`ifdef REG_DUMP_HDR_EN
    input  logic [4:0]  index,
`endif
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        last_accept
);

    localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_REG - 1);

    logic [31:0] snapshot_r;
    logic [2:0]  byte_idx_r;
    logic        valid_r;
    logic        accept_s;
    logic [7:0]  tx_data_s;
`ifdef REG_DUMP_HDR_EN
    logic [4:0]  hdr_idx_r;
`endif

    assign accept_s    = valid_r & tx_ready;
    assign last_accept = accept_s && (byte_idx_r == LAST_IDX);

    // Snapshot capture and byte stepping; the snapshot is frozen until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snapshot_r <= 32'h0000_0000;
            byte_idx_r <= 3'd0;
            valid_r    <= 1'b0;
`ifdef REG_DUMP_HDR_EN
            hdr_idx_r  <= 5'd0;
`endif
        end else if (load) begin
            snapshot_r <= word;
            byte_idx_r <= 3'd0;
            valid_r    <= 1'b1;
`ifdef REG_DUMP_HDR_EN
            hdr_idx_r  <= index;
`endif
        end else if (accept_s) begin
            if (byte_idx_r == LAST_IDX) begin
                valid_r    <= 1'b0;
                byte_idx_r <= 3'd0;
            end else begin
                byte_idx_r <= byte_idx_r + 3'd1;
            end
        end else begin
            byte_idx_r <= byte_idx_r;
        end
    end

    // Byte mux driven purely from registers, so tx_data holds while stalled.
    always_comb begin
        tx_data_s = 8'h00;
`ifdef REG_DUMP_HDR_EN
        if (byte_idx_r == 3'd0) begin
            tx_data_s = hdr_byte(hdr_idx_r);
        end else begin
            tx_data_s = word_byte(snapshot_r, byte_idx_r - 3'd1);
        end
`else
        tx_data_s = word_byte(snapshot_r, byte_idx_r);
`endif
    end

    assign tx_valid = valid_r;
    assign tx_data  = tx_data_s;

endmodule

// File: rtl/reg_dump.sv
// Register-file dump engine: walks FIRST_REG..LAST_REG and streams each register as bytes.
// Optional REG_DUMP_HDR_EN prefixes every register with its index byte.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    generate
        if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
            $error("reg_dump: need 0 <= FIRST_REG <= LAST_REG <= 31");
        end
    endgenerate

    localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
    localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

    state_t      state_r;
    state_t      next_state_s;
    logic [4:0]  addr_r;
    logic        busy_r;
    logic        done_r;
    logic        load_s;
    logic        last_accept_s;

    assign load_s = (state_r == ST_FETCH);

    // Next-state logic; start outside IDLE has no effect.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_FETCH;
                else       next_state_s = ST_IDLE;
            end
            ST_FETCH: next_state_s = ST_SEND;
            ST_SEND: begin
                if (last_accept_s) begin
                    if (addr_r < LAST_ADDR) next_state_s = ST_FETCH;
                    else                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SEND;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, address counter and status outputs, all registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            addr_r  <= FIRST_ADDR;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == ST_FETCH) || (next_state_s == ST_SEND);
            done_r  <= (next_state_s == ST_DONE);
            // The counter stops at LAST_ADDR, so LAST_REG=31 never wraps.
            if (state_r == ST_IDLE && start) begin
                addr_r <= FIRST_ADDR;
            end else if (state_r == ST_SEND && last_accept_s && addr_r < LAST_ADDR) begin
                addr_r <= addr_r + 5'd1;
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    reg_dump_ser u_ser (
        .clk         (clk),
        .rst         (rst),
        .load        (load_s),
        .word        (rd_data),
`ifdef REG_DUMP_HDR_EN
        .index       (addr_r),
`endif
        .tx_ready    (tx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .last_accept (last_accept_s)
    );

    assign rd_addr = addr_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_reg_dump.sv
// Directed self-checking bench for reg_dump: full dumps, stalls, restarts, reset abort, sub-range.
module tb_reg_dump;

`ifdef REG_DUMP_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int BPR = 4 + HDR;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        tx_ready0 = 1'b1, tx_ready1 = 1'b1;
    logic [4:0]  rd_addr0, rd_addr1;
    logic [31:0] rd_data0, rd_data1;
    logic        tx_valid0, tx_valid1, busy0, busy1, done0, done1;
    logic [7:0]  tx_data0, tx_data1;
    logic [31:0] rf0 [32];
    logic [31:0] rf1 [32];

    logic [7:0] bytes0[$];
    logic [7:0] bytes1[$];
    logic [7:0] exp1[$];
    int busy_cnt0 = 0, done_cnt0 = 0, done_cnt1 = 0;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    assign rd_data0 = rf0[rd_addr0];
    assign rd_data1 = rf1[rd_addr1];

    reg_dump dut0 (
        .clk(clk), .rst(rst), .start(start0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .tx_valid(tx_valid0), .tx_data(tx_data0), .tx_ready(tx_ready0),
        .busy(busy0), .done(done0)
    );

    reg_dump #(.FIRST_REG(3), .LAST_REG(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .tx_valid(tx_valid1), .tx_data(tx_data1), .tx_ready(tx_ready1),
        .busy(busy1), .done(done1)
    );

    // Byte and status monitor at the accepting edge.
    always @(posedge clk) begin
        if (!rst) begin
            if (tx_valid0 && tx_ready0) bytes0.push_back(tx_data0);
            if (tx_valid1 && tx_ready1) bytes1.push_back(tx_data1);
            if (busy0) busy_cnt0++;
            if (done0) done_cnt0++;
            if (done1) done_cnt1++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        bytes0.delete();
        bytes1.delete();
        busy_cnt0 = 0;
        done_cnt0 = 0;
        done_cnt1 = 0;
    endtask

    task automatic pulse_start0();
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
    endtask

    task automatic wait_done0(input string tag);
        int n = 0;
        while (!done0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, done0}, 32'd1);
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_bytes0(input int cnt, input string tag);
        int n = 0;
        while (bytes0.size() < cnt && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(tag, bytes0.size(), cnt);
    endtask

    task automatic check_x5_x6(input string tag);
        logic [7:0] e5 [4];
        logic [7:0] e6 [4];
        e5 = '{8'h1F, 8'h00, 8'h00, 8'h00};
        e6 = '{8'h06, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            check({tag, "_x5"}, {24'd0, bytes0[5*BPR + HDR + i]}, {24'd0, e5[i]});
            check({tag, "_x6"}, {24'd0, bytes0[6*BPR + HDR + i]}, {24'd0, e6[i]});
        end
    endtask

    initial begin
        logic [7:0] held;
        for (int i = 0; i < 32; i++) begin
            rf0[i] = 32'h0;
            rf1[i] = 32'h0;
        end
        rf0[5] = 32'h0000_001F;
        rf0[6] = 32'h0000_0006;
        rf1[3] = 32'h0000_00BA;
        rf1[4] = 32'h0000_0005;

        // Reset state
        @(negedge clk);
        check("rst_tx_valid", {31'd0, tx_valid0}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data0}, 32'd0);
        check("rst_rd_addr", {27'd0, rd_addr0}, 32'd0);
        check("rst_rd_addr_sub", {27'd0, rd_addr1}, 32'd3);
        @(negedge clk) rst = 1'b0;

        // Plain full dump
        clear_mon();
        pulse_start0();
        wait_done0("dump_done");
        check("dump_bytes", bytes0.size(), 32 * BPR);
        check_x5_x6("dump");
        check("dump_busy_cycles", busy_cnt0, 32 * (1 + BPR));
        check("dump_done_cnt", done_cnt0, 1);
        check("dump_idle_busy", {31'd0, busy0}, 32'd0);

        // Backpressure on byte 2 of x5
        clear_mon();
        pulse_start0();
        wait_bytes0(5*BPR + HDR + 2, "stall_reach");
        tx_ready0 = 1'b0;
        held = tx_data0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, tx_valid0}, 32'd1);
            check("stall_data", {24'd0, tx_data0}, {24'd0, held});
        end
        check("stall_byte_val", {24'd0, held}, 32'h00);
        tx_ready0 = 1'b1;
        wait_done0("stall_done");
        check("stall_bytes", bytes0.size(), 32 * BPR);
        check_x5_x6("stall");
        check("stall_done_cnt", done_cnt0, 1);

        // Second start mid-dump is ignored
        clear_mon();
        pulse_start0();
        repeat (39) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        wait_done0("restart_done");
        repeat (20) @(negedge clk);
        check("restart_bytes", bytes0.size(), 32 * BPR);
        check("restart_done_cnt", done_cnt0, 1);
        check("restart_idle_busy", {31'd0, busy0}, 32'd0);

        // Reset abort after byte 50 accepted
        clear_mon();
        pulse_start0();
        wait_bytes0(51, "abort_reach");
        rst = 1'b1;
        #1;
        check("abort_tx_valid", {31'd0, tx_valid0}, 32'd0);
        check("abort_busy", {31'd0, busy0}, 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_more_bytes", bytes0.size(), 51);
        check("abort_no_done", done_cnt0, 0);
        clear_mon();
        pulse_start0();
        wait_done0("abort_rerun_done");
        check("abort_rerun_bytes", bytes0.size(), 32 * BPR);
        check_x5_x6("abort_rerun");

        // Sub-range instance FIRST_REG=3, LAST_REG=4
        clear_mon();
`ifdef REG_DUMP_HDR_EN
        exp1 = '{8'h03, 8'hBA, 8'h00, 8'h00, 8'h00, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00};
`else
        exp1 = '{8'hBA, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
`endif
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        for (int n = 0; n < 200 && !done1; n++) @(negedge clk);
        check("sub_done", {31'd0, done1}, 32'd1);
        repeat (5) @(negedge clk);
        check("sub_bytes", bytes1.size(), exp1.size());
        for (int i = 0; i < exp1.size(); i++)
            check("sub_stream", {24'd0, bytes1[i]}, {24'd0, exp1[i]});
        check("sub_done_cnt", done_cnt1, 1);

        // Write to x5 while its bytes are in flight
        clear_mon();
        pulse_start0();
        wait_bytes0(5*BPR + HDR + 1, "snap_reach");
        rf0[5] = 32'h4000_1100;
        wait_done0("snap_done");
        check("snap_bytes", bytes0.size(), 32 * BPR);
        check_x5_x6("snap");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
